// File: rtl/sid_wave_if.sv
// rtl/sid_wave_if.sv - waveform generator oscillator inputs and output bundle
interface sid_wave_if;
    logic        clk_en;
    logic [23:0] acc;
    logic [22:0] lfsr;
    logic        ring_msb;
    logic [11:0] pw;
    logic        sel_tri;
    logic        sel_saw;
    logic        sel_pulse;
    logic        sel_noise;
    logic        ring;
    logic        test;
    logic [11:0] wave;
    logic [7:0]  osc3;

    modport master (
        output clk_en, acc, lfsr, ring_msb, pw,
        output sel_tri, sel_saw, sel_pulse, sel_noise, ring, test,
        input  wave, osc3
    );

    modport slave (
        input  clk_en, acc, lfsr, ring_msb, pw,
        input  sel_tri, sel_saw, sel_pulse, sel_noise, ring, test,
        output wave, osc3
    );
endinterface

// File: rtl/sid_wave.sv
// rtl/sid_wave.sv - SID voice waveform selector with held-output fade timer
module sid_wave #(
    parameter logic [15:0] FADE_HOLD = 16'h4000
) (
    input logic        clk,
    input logic        n_reset,
    sid_wave_if.slave  bus
);

    logic [11:0] wave_q, wave_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tri_msb;
    logic [11:0] tri_wave;
    logic [11:0] saw_wave;
    logic [11:0] pulse_wave;
    logic [11:0] noise_wave;
    logic [11:0] mix;
    logic        any_sel;

    always_comb begin
        tri_msb    = bus.acc[23] ^ (bus.ring & bus.ring_msb);
        tri_wave   = {bus.acc[22:12] ^ {11{tri_msb}}, 1'b0};
        saw_wave   = bus.acc[23:12];
        pulse_wave = (bus.test || (bus.acc[23:12] >= bus.pw)) ? 12'hFFF : 12'h000;
        noise_wave = {bus.lfsr[22], bus.lfsr[20], bus.lfsr[16], bus.lfsr[13],
                      bus.lfsr[11], bus.lfsr[7], bus.lfsr[4], bus.lfsr[2], 4'b0000};

        // Combined waveforms are the AND of every selected source.
        mix = 12'hFFF;
        if (bus.sel_tri)   mix = mix & tri_wave;
        if (bus.sel_saw)   mix = mix & saw_wave;
        if (bus.sel_pulse) mix = mix & pulse_wave;
        if (bus.sel_noise) mix = mix & noise_wave;
        any_sel = bus.sel_tri | bus.sel_saw | bus.sel_pulse | bus.sel_noise;
    end

    always_comb begin
        wave_d = wave_q;
        cnt_d  = cnt_q;
        if (bus.clk_en) begin
            if (any_sel) begin
                wave_d = mix;
                cnt_d  = 16'd0;
            end else begin
                // Saturating count; reaching the limit (including a limit of 0) clears the held wave.
                cnt_d = (cnt_q >= FADE_HOLD) ? FADE_HOLD : cnt_q + 16'd1;
                if (cnt_d == FADE_HOLD) wave_d = 12'h000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wave_q <= 12'h000;
            cnt_q  <= 16'd0;
        end else begin
            wave_q <= wave_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.wave = wave_q;
    assign bus.osc3 = wave_q[11:4];

endmodule

// File: tb/tb_sid_wave.sv
// tb/tb_sid_wave.sv - directed vector and sequence checks for sid_wave
module tb_sid_wave;

    logic clk;
    logic n_reset;
    int   tests;
    int   failed;

    sid_wave_if bus ();

    sid_wave #(.FADE_HOLD(16'd4)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  sel;
        logic        ring;
        logic        ring_msb;
        logic        test;
        logic [23:0] acc;
        logic [22:0] lfsr;
        logic [11:0] pw;
        logic [11:0] exp_wave;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp_w);
        tests++;
        if (act !== exp_w) begin
            failed++;
            $display("FAIL %s: wave got %h expected %h", name, act, exp_w);
        end
        tests++;
        if (bus.osc3 !== exp_w[11:4]) begin
            failed++;
            $display("FAIL %s_osc3: osc3 got %h expected %h", name, bus.osc3, exp_w[11:4]);
        end
    endtask

    task automatic set_sel(input logic [3:0] s);
        {bus.sel_tri, bus.sel_saw, bus.sel_pulse, bus.sel_noise} = s;
    endtask

    task automatic tick();
        bus.clk_en = 1'b1;
        @(negedge clk);
        bus.clk_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        tests  = 0;
        failed = 0;

        // sel = {tri, saw, pulse, noise}
        vecs[0]  = '{"saw_abc",      4'b0100, 0, 0, 0, 24'hABC123, 23'h0,      12'h000, 12'hABC};
        vecs[1]  = '{"tri_ring",     4'b1000, 1, 1, 0, 24'h012345, 23'h0,      12'h000, 12'hFDA};
        vecs[2]  = '{"tri_plain",    4'b1000, 0, 1, 0, 24'h012345, 23'h0,      12'h000, 12'h024};
        vecs[3]  = '{"pulse_below",  4'b0010, 0, 0, 0, 24'h7FF000, 23'h0,      12'h800, 12'h000};
        vecs[4]  = '{"pulse_equal",  4'b0010, 0, 0, 0, 24'h800000, 23'h0,      12'h800, 12'hFFF};
        vecs[5]  = '{"pulse_test",   4'b0010, 0, 0, 1, 24'h000000, 23'h0,      12'h800, 12'hFFF};
        vecs[6]  = '{"saw_pulse_hi", 4'b0110, 0, 0, 0, 24'h5A5000, 23'h0,      12'h100, 12'h5A5};
        vecs[7]  = '{"saw_pulse_lo", 4'b0110, 0, 0, 0, 24'h0A5000, 23'h0,      12'h100, 12'h000};
        vecs[8]  = '{"noise_all",    4'b0001, 0, 0, 0, 24'h000000, 23'h7FFFFF, 12'h000, 12'hFF0};
        vecs[9]  = '{"noise_bits",   4'b0001, 0, 0, 0, 24'h000000, 23'h400004, 12'h000, 12'h810};
        vecs[10] = '{"pw_zero",      4'b0010, 0, 0, 0, 24'h000000, 23'h0,      12'h000, 12'hFFF};
        vecs[11] = '{"pw_max_lo",    4'b0010, 0, 0, 0, 24'hFFE000, 23'h0,      12'hFFF, 12'h000};
        vecs[12] = '{"pw_max_hi",    4'b0010, 0, 0, 0, 24'hFFF000, 23'h0,      12'hFFF, 12'hFFF};
        vecs[13] = '{"tri_saw",      4'b1100, 0, 0, 0, 24'hF00000, 23'h0,      12'h000, 12'h100};

        n_reset      = 1'b0;
        bus.clk_en   = 1'b0;
        bus.acc      = 24'h0;
        bus.lfsr     = 23'h0;
        bus.ring_msb = 1'b0;
        bus.pw       = 12'h0;
        bus.ring     = 1'b0;
        bus.test     = 1'b0;
        set_sel(4'b0000);
        idle(3);
        check("reset", bus.wave, 12'h000);
        n_reset = 1'b1;
        idle(1);

        foreach (vecs[i]) begin
            set_sel(vecs[i].sel);
            bus.ring     = vecs[i].ring;
            bus.ring_msb = vecs[i].ring_msb;
            bus.test     = vecs[i].test;
            bus.acc      = vecs[i].acc;
            bus.lfsr     = vecs[i].lfsr;
            bus.pw       = vecs[i].pw;
            tick();
            check(vecs[i].name, bus.wave, vecs[i].exp_wave);
        end
        bus.ring = 1'b0;
        bus.test = 1'b0;

        // Without clk_en nothing moves even with new inputs.
        set_sel(4'b0100);
        bus.acc = 24'h123000;
        tick();
        check("load_123", bus.wave, 12'h123);
        bus.acc = 24'h777000;
        idle(3);
        check("no_en_hold", bus.wave, 12'h123);

        // Fade: hold for 3 ticks, clear on the 4th, stay clear.
        set_sel(4'b0000);
        tick(); check("fade_1", bus.wave, 12'h123);
        tick(); check("fade_2", bus.wave, 12'h123);
        tick(); check("fade_3", bus.wave, 12'h123);
        tick(); check("fade_4", bus.wave, 12'h000);
        tick(); check("fade_5", bus.wave, 12'h000);

        // Reselect on the 2nd tick restarts the count.
        set_sel(4'b0100);
        bus.acc = 24'h123000;
        tick();
        set_sel(4'b0000);
        tick(); check("resel_1", bus.wave, 12'h123);
        set_sel(4'b0100);
        bus.acc = 24'h456000;
        tick(); check("resel_saw", bus.wave, 12'h456);
        set_sel(4'b0000);
        tick(); check("resel_f1", bus.wave, 12'h456);
        tick(); check("resel_f2", bus.wave, 12'h456);
        tick(); check("resel_f3", bus.wave, 12'h456);
        tick(); check("resel_f4", bus.wave, 12'h000);

        // Reset mid-fade with clk_en low.
        set_sel(4'b0100);
        bus.acc = 24'h9AB000;
        tick();
        set_sel(4'b0000);
        tick();
        tick();
        check("pre_reset", bus.wave, 12'h9AB);
        n_reset = 1'b0;
        @(negedge clk);
        check("reset_mid", bus.wave, 12'h000);
        n_reset = 1'b1;

        // Reset wins over a simultaneous clk_en with a select.
        set_sel(4'b0100);
        bus.acc = 24'hDEF000;
        n_reset = 1'b0;
        tick();
        check("reset_over_en", bus.wave, 12'h000);
        n_reset = 1'b1;

        // First clk_en after release updates normally, then a full hold follows.
        tick(); check("post_rst_load", bus.wave, 12'hDEF);
        set_sel(4'b0000);
        tick(); check("post_f1", bus.wave, 12'hDEF);
        tick(); check("post_f2", bus.wave, 12'hDEF);
        tick(); check("post_f3", bus.wave, 12'hDEF);
        tick(); check("post_f4", bus.wave, 12'h000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sid_wave.md
SID_WAVE -- requirements
Module: sid_wave

Interface
REQ-001 Parameter FADE_HOLD, default 16'h4000: number of clk_en cycles with no waveform selected before the held output clears.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 n_reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 clk_en  input  1  one-cycle SID tick enable; state advances only when clk_en=1.
REQ-005 acc  input  24  phase accumulator of this voice.
REQ-006 lfsr  input  23  noise LFSR of this voice.
REQ-007 ring_msb  input  1  acc[23] of the ring-modulation source voice.
REQ-008 pw  input  12  pulse width.
REQ-009 sel_tri, sel_saw, sel_pulse, sel_noise  input  1 each  waveform selects.
REQ-010 ring, test  input  1 each  ring-modulation enable; oscillator test bit.
REQ-011 wave  output  12  registered waveform output.
REQ-012 osc3  output  8  readback value, equal to wave[11:4] at all times.

Function
REQ-013 Sawtooth SHALL be acc[23:12].
REQ-014 Triangle SHALL use msb = acc[23] XOR (ring AND ring_msb); tri[11:1] = acc[22:12] XOR {11{msb}}; tri[0] = 0.
REQ-015 Pulse SHALL be 12'hFFF when test=1 or acc[23:12] >= pw (unsigned), else 12'h000.
REQ-016 Noise SHALL be {lfsr[22],lfsr[20],lfsr[16],lfsr[13],lfsr[11],lfsr[7],lfsr[4],lfsr[2],4'b0000}.
REQ-017 With one or more selects high, the next output SHALL be the bitwise AND of all selected waveforms.
REQ-018 On each clk_en with any select high, wave SHALL load the REQ-017 value (latency: one clk_en) and the fade counter SHALL load 0.
REQ-019 On each clk_en with all selects low, wave SHALL hold and the 16-bit fade counter SHALL increment, saturating at FADE_HOLD.
REQ-020 On the clk_en where the counter reaches FADE_HOLD (increments from FADE_HOLD-1), wave SHALL load 12'h000; wave stays 0 while the counter remains saturated.
REQ-021 A select going high at any counter value SHALL restart normal operation per REQ-018 on that clk_en, with no fade effect.
REQ-022 With clk_en=0, wave and counter SHALL hold regardless of other inputs.
REQ-023 FADE_HOLD=0 SHALL clear wave on the first clk_en with all selects low.
REQ-024 The block SHALL be fully combinational from inputs to next-state; no input is registered except via wave and the counter.
REQ-025 pw=12'h000 SHALL give constant pulse high; pw=12'hFFF SHALL give pulse high only when acc[23:12]=12'hFFF.

Reset
REQ-026 With n_reset=0 at a rising clk, wave SHALL become 12'h000 and the fade counter 0, regardless of clk_en.
REQ-027 Reset SHALL override a fade in progress; after release the counter restarts from 0.
REQ-028 The first clk_en after reset release SHALL update state normally per REQ-018/REQ-019.

Verification
REQ-029 sel_saw=1, acc=24'hABC123, clk_en pulse -> wave=12'hABC, osc3=8'hAB.
REQ-030 sel_tri=1, ring=1, ring_msb=1, acc=24'h012345 -> msb=1, wave=12'hFDA (tri[11:1]=acc[22:12]^7FF).
REQ-031 sel_pulse=1, pw=12'h800: acc=24'h7FF000 -> 12'h000; acc=24'h800000 -> 12'hFFF; test=1 with acc=0 -> 12'hFFF.
REQ-032 sel_saw=sel_pulse=1, pw=12'h100, acc=24'h5A5000 -> wave=12'h5A5; with acc=24'h0A5000 -> 12'h000.
REQ-033 FADE_HOLD=4: wave=12'h123, all selects low -> wave holds 12'h123 for 3 clk_en, 12'h000 on the 4th; reselecting sel_saw on the 2nd restores sawtooth with no clear.
REQ-034 Assert n_reset=0 mid-fade with clk_en=0 -> wave=12'h000 next clk; after release, fade count restarts from 0 (full FADE_HOLD hold observed).
